// File: rtl/al_accel_mem_arbiter_pkg.sv
// Shared definitions for the accelerator memory-port arbiter: FSM state encodings,
// the default starvation bound and the grant-selection helper.
package al_accel_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_e;

    localparam int STARVE_MAX_DEFAULT = 8;

    // Writes win unless a read is pending and has already been passed over too often.
    function automatic logic pick_write(input logic rd_pend, input logic wr_pend,
                                        input logic starve_hit);
        return wr_pend & ~(rd_pend & starve_hit);
    endfunction

endpackage

// File: rtl/al_accel_mem_arbiter.sv
// Single-outstanding read/write arbiter onto the SoC memory port, write-priority with a
// starvation bound for reads. Optional ack statistics: define AL_ACCEL_ARB_STATS_EN.
module al_accel_mem_arbiter
    import al_accel_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enb,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_ack,
    output logic [DATA_W-1:0]   rd_rdata,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_wdata,
    input  logic [DATA_W/8-1:0] wr_wstrb,
    output logic                wr_ack,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_busy
`ifdef AL_ACCEL_ARB_STATS_EN
    ,
    output logic [15:0]         rd_cnt,
    output logic [15:0]         wr_cnt
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e          state_q, state_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;
    logic                starve_hit;

    assign starve_hit = (starve_q >= SW'(STARVE_MAX));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rd_ack      = 1'b0;
        wr_ack      = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (enb && (rd_req || wr_req)) begin
                    if (pick_write(rd_req, wr_req, starve_hit)) begin
                        state_d     = ARB_WR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_addr;
                        mem_wdata_d = wr_wdata;
                        mem_wstrb_d = wr_wstrb;
                        if (rd_req && !starve_hit) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        state_d     = ARB_RD;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = rd_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            ARB_RD: begin
                if (mem_ready) begin
                    rd_ack  = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            ARB_WR: begin
                if (mem_ready) begin
                    wr_ack  = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign mem_valid = (state_q != ARB_IDLE);
    assign arb_busy  = (state_q != ARB_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rd_rdata  = mem_rdata;

`ifdef AL_ACCEL_ARB_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_ack) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (wr_ack) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_al_accel_mem_arbiter.sv
// Directed bench for al_accel_mem_arbiter: expected transfers are queued at grant time
// and compared while the DUT drives the memory port. Honours AL_ACCEL_ARB_STATS_EN.
module tb_al_accel_mem_arbiter;

    localparam int STARVE = 8;

    logic        clk;
    logic        resetn;
    logic        enb;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_rdata;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_wdata;
    logic [3:0]  wr_wstrb;
    logic        wr_ack;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        arb_busy;
`ifdef AL_ACCEL_ARB_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    al_accel_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enb       (enb),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_rdata  (rd_rdata),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_wdata  (wr_wdata),
        .wr_wstrb  (wr_wstrb),
        .wr_ack    (wr_ack),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .arb_busy  (arb_busy)
`ifdef AL_ACCEL_ARB_STATS_EN
        ,
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_starve = 0;
    int   exp_rd_cnt = 0;
    int   exp_wr_cnt = 0;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_busy"},  32'(arb_busy),  32'd0);
        check({tag, "_acks"},  32'({rd_ack, wr_ack}), 32'd0);
    endtask

    task automatic check_stats();
`ifdef AL_ACCEL_ARB_STATS_EN
        check("rd_cnt", 32'(rd_cnt), 32'(exp_rd_cnt));
        check("wr_cnt", 32'(wr_cnt), 32'(exp_wr_cnt));
`endif
    endtask

    // Predict the grant the arbiter makes at the coming edge, queue it, then take the edge.
    task automatic grant(input logic [31:0] rdata);
        txn_t t;
        if (wr_req && !(rd_req && model_starve >= STARVE)) begin
            if (rd_req) model_starve++;
            t.we = 1'b1; t.addr = wr_addr; t.wdata = wr_wdata; t.wstrb = wr_wstrb; t.rdata = '0;
        end else begin
            model_starve = 0;
            t.we = 1'b0; t.addr = rd_addr; t.wdata = '0; t.wstrb = '0; t.rdata = rdata;
        end
        sb.push_back(t);
        tick();
    endtask

    // Hold mem_ready low for `delay` cycles, then complete; checks the bus every cycle.
    task automatic service(input int delay);
        txn_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected pending transfer");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i <= delay; i++) begin
            mem_ready = (i == delay);
            mem_rdata = (i == delay) ? e.rdata : (32'h0BAD_0000 | 32'(i));
            #1;
            check("mem_valid", 32'(mem_valid), 32'd1);
            check("mem_we",    32'(mem_we),    32'(e.we));
            check("mem_addr",  mem_addr,       e.addr);
            check("mem_wdata", mem_wdata,      e.wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
            check("rd_ack",    32'(rd_ack),    32'(!e.we && i == delay));
            check("wr_ack",    32'(wr_ack),    32'(e.we && i == delay));
            if (i == delay && !e.we) check("rd_rdata", rd_rdata, e.rdata);
            if (i < delay) tick();
        end
        if (e.we) exp_wr_cnt++; else exp_rd_cnt++;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        clk = 0; resetn = 0; enb = 1;
        rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_wdata = '0; wr_wstrb = '0;
        mem_ready = 0; mem_rdata = '0;

        // Reset and quiet idle
        repeat (3) tick();
        check_idle("in_reset");
        resetn = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle("post_reset");
            check("rst_mem_we",    32'(mem_we),    32'd0);
            check("rst_mem_addr",  mem_addr,       32'd0);
            check("rst_mem_wdata", mem_wdata,      32'd0);
            check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        end
        mem_rdata = 32'h1234_5678;
        #1;
        check("rdata_passthru", rd_rdata, 32'h1234_5678);
        check_stats();

        // Single read, ready on the third valid cycle
        rd_req = 1; rd_addr = 32'h0000_1000;
        grant(32'hDEAD_BEEF);
        service(2);
        rd_req = 0;
        check_idle("after_read");

        // Contention with ready always high: 8 writes then 1 read, twice
        rd_addr = 32'h0000_2000; wr_addr = 32'h0000_3000;
        wr_wdata = 32'hCAFE_0001; wr_wstrb = 4'hF;
        rd_req = 1; wr_req = 1;
        for (int n = 0; n < 18; n++) begin
            grant(32'h7700_0000 + 32'(n));
            service(0);
            check_idle("contend_gap");
            wr_wdata = wr_wdata + 32'd1;
        end
        rd_req = 0; wr_req = 0;
        check_stats();

        // Write held off by a slow bus; request fields must stay registered
        wr_req = 1; wr_addr = 32'h0000_4000; wr_wdata = 32'hA5A5_1234; wr_wstrb = 4'b0011;
        grant('0);
        service(5);
        wr_req = 0;

        // enb dropped mid-write with a read pending: no read until enb returns
        rd_req = 1; rd_addr = 32'h0000_5000;
        wr_req = 1; wr_addr = 32'h0000_6000; wr_wdata = 32'h0F0F_F0F0; wr_wstrb = 4'b1100;
        grant('0);
        enb = 0;
        service(1);
        wr_req = 0;
        for (int c = 0; c < 4; c++) begin
            check_idle("enb_low");
            tick();
        end
        enb = 1;
        grant(32'h5555_AAAA);
        service(0);
        rd_req = 0;
        check_stats();

        // Reset pulse mid-read: outputs clear at once, held request is regranted
        rd_req = 1; rd_addr = 32'h0000_7000;
        grant(32'h1111_2222);
        check("abort_pre_valid", 32'(mem_valid), 32'd1);
        #2;
        resetn = 0;
        #1;
        void'(sb.pop_back());
        model_starve = 0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        check_idle("abort");
        check("abort_mem_addr", mem_addr, 32'd0);
        check_stats();
        #1;
        resetn = 1;
        grant(32'h3333_4444);
        service(1);
        rd_req = 0;
        check_idle("final");
        check_stats();

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
